// File: rtl/line_buffer_array.sv
// ROWS-deep circular line buffer with a valid/ready pixel input, a registered packed column
// output and an end-of-frame flush. Define LB_BORDER_REPLICATE_EN to pad the flush with the previous line.
module line_buffer_array #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 12,
  parameter int LINE_W = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       done_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [(ROWS+1)*DATA_W-1:0] rows_o,
  output logic [$clog2(LINE_W)-1:0]  col_o,
  output logic                       done_o
);

  localparam int CW = $clog2(LINE_W);
  localparam int LW = $clog2(ROWS + 1);
  localparam int FW = $clog2(ROWS * LINE_W + LINE_W + 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(LINE_W - 1);
  localparam logic [LW-1:0] LINE_FULL  = LW'(ROWS);
  localparam logic [FW-1:0] FLUSH_BASE = FW'(ROWS * LINE_W + LINE_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                       state_q;
  logic                         ready_q;
  logic                         valid_q;
  logic                         done_q;
  logic [CW-1:0]                col_q;
  logic [CW-1:0]                col_d;
  logic [LW-1:0]                line_q;
  logic [LW-1:0]                line_d;
  logic [FW-1:0]                flush_cnt_q;
  logic [CW-1:0]                col_out_q;
  logic [DATA_W-1:0]            tap0_q;
  logic [DATA_W-1:0]            tap0_out;
  logic                         wr_en_q;
  logic [CW-1:0]                wr_ptr_q;
  logic [ROWS-1:0][DATA_W-1:0]  rd_bus;

  logic accept;
  logic flush_step;
  logic shift;
  logic col_wrap;

  assign accept     = valid_i & ready_q;
  assign flush_step = (state_q == FLUSH);
  assign shift      = accept | flush_step;
  assign col_wrap   = (col_q == COL_LAST);

  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (shift) begin
      col_d = col_wrap ? '0 : col_q + 1'b1;
      if (col_wrap && (line_q != LINE_FULL)) begin
        line_d = line_q + 1'b1;
      end
    end
  end

  // Frame control: the flush runs until every real line has reached tap ROWS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      col_q       <= '0;
      line_q      <= '0;
      flush_cnt_q <= '0;
      col_out_q   <= '0;
    end else begin
      valid_q <= shift & ((line_q == LINE_FULL) | flush_step);
      done_q  <= 1'b0;
      col_q   <= col_d;
      line_q  <= line_d;
      if (shift) begin
        col_out_q <= col_q;
      end
      case (state_q)
        IDLE, RUN: begin
          if (accept) begin
            if (done_i) begin
              state_q     <= FLUSH;
              ready_q     <= 1'b0;
              flush_cnt_q <= FLUSH_BASE - FW'(col_q);
            end else begin
              state_q <= RUN;
            end
          end
        end
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q - 1'b1;
          if (flush_cnt_q == FW'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
          col_q   <= '0;
          line_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory writes trail the shift by one cycle; consecutive shifts always hit different
  // columns (LINE_W >= 2), so a read never collides with its pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap0_q   <= '0;
      wr_en_q  <= 1'b0;
      wr_ptr_q <= '0;
    end else begin
      wr_en_q <= shift;
      if (shift) begin
        wr_ptr_q <= col_q;
        tap0_q   <= flush_step ? '0 : data_i;
      end
    end
  end

`ifdef LB_BORDER_REPLICATE_EN
  logic pad_rep_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_rep_q <= 1'b0;
    end else if (shift) begin
      pad_rep_q <= flush_step;
    end
  end

  assign tap0_out = pad_rep_q ? rd_bus[0] : tap0_q;
`else
  assign tap0_out = tap0_q;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_line
      logic [DATA_W-1:0] mem [LINE_W];
      logic [DATA_W-1:0] rd_q;

      always_ff @(posedge clk) begin
        if (wr_en_q) begin
          mem[wr_ptr_q] <= rows_o[gi*DATA_W +: DATA_W];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q <= '0;
        end else if (shift) begin
          rd_q <= mem[col_q];
        end
      end

      assign rd_bus[gi] = rd_q;
    end
  endgenerate

  assign rows_o  = {rd_bus, tap0_out};
  assign col_o   = col_out_q;
  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign done_o  = done_q;

endmodule
